// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract unit. Each stage resolves one SEG-bit carry-lookahead
// segment; a single global stall freezes the whole pipe under output backpressure.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = WIDTH / SEG;

  logic stall;

  // Returns {carry_out, sum} of one generate/propagate segment.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG:0]   c;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]      xa;
    logic [REM-1:0]      xb;
    logic                xc;
    logic                xv;
    logic [SEG:0]        sr;
    logic [LO+SEG-1:0]   s_d;
    logic                vld_q;
    logic                c_q;
    logic [LO+SEG-1:0]   s_q;

    if (k == 0) begin : g_src
      assign xa  = a;
      assign xb  = sub ? ~b : b;
      assign xc  = sub | cin;
      assign xv  = in_valid;
      assign s_d = sr[SEG-1:0];
    end else begin : g_src
      assign xa  = g_stg[k-1].g_skew.a_q;
      assign xb  = g_stg[k-1].g_skew.b_q;
      assign xc  = g_stg[k-1].c_q;
      assign xv  = g_stg[k-1].vld_q;
      assign s_d = {sr[SEG-1:0], g_stg[k-1].s_q};
    end

    assign sr = cla_seg(xa[SEG-1:0], xb[SEG-1:0], xc);

    // Data registers only load on a valid beat so a bubble leaves the last result intact.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else if (!stall) begin
        vld_q <= xv;
        if (xv) begin
          c_q <= sr[SEG];
          s_q <= s_d;
        end
      end
    end

    if (k < NSTG - 1) begin : g_skew
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall && xv) begin
          a_q <= xa[REM-1:SEG];
          b_q <= xb[REM-1:SEG];
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered as a^b^s at that bit.
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall && xv) begin
          ovf_q <= xa[SEG-1] ^ xb[SEG-1] ^ sr[SEG-1] ^ sr[SEG];
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].vld_q;
  assign sum       = g_stg[NSTG-1].s_q;
  assign cout      = g_stg[NSTG-1].c_q;
  assign ovf       = g_stg[NSTG-1].g_last.ovf_q;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed latency/backpressure/reset
// cases plus a randomized handshake regression against an arithmetic model.
module tb_pipelined_cla_adder;

  localparam int W     = 16;
  localparam int S     = 4;
  localparam int N     = W / S;
  localparam int NRAND = 10000;
  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 1;
  localparam longint SMIN = -SMAX - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  pipelined_cla_adder #(.WIDTH(W), .SEG(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t exp_q[$];
  int   fire_cyc[$];
  res_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_in = 0;
  int   n_out = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    res_t   r;
    longint full;
    longint u;
    if (sb) begin
      full = longint'($signed(x)) - longint'($signed(y));
      r.c  = (x >= y);
    end else begin
      full = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      u    = longint'(x) + longint'(y) + longint'(ci);
      r.c  = u[W];
    end
    r.s = full[W-1:0];
    r.o = (full > SMAX) || (full < SMIN);
    return r;
  endfunction

  // Handshakes are evaluated mid-cycle; they take effect at the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        chk("out_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
          chk("ovf", ovf, e.o);
        end
        n_out++;
        fire_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        n_in++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sb);
    logic acc;
    int   n;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end
    chk("issue_accept", acc, 1);
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic measure_latency(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb,
                                 input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    issue(x, y, ci, sb);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, N);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {(W-1){1'b1}}};
      3:       v = {1'b1, {(W-1){1'b0}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int c0;
    int o0;
    int i0;
    int issued;
    int guard;
    logic acc;
    logic [W-1:0] held;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    step();
    rst_n = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);

    // Wrap-around add with carry out
    measure_latency("t1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain();

    // Signed overflow in add, then sub with cin ignored
    issue(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    issue(16'h8000, 16'h0001, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_out("t2_wait");
    chk("t2a_sum", sum, 16'h8000);
    chk("t2a_cout", cout, 0);
    chk("t2a_ovf", ovf, 1);
    step();
    chk("t2b_valid", out_valid, 1);
    chk("t2b_sum", sum, 16'h7FFF);
    chk("t2b_cout", cout, 1);
    chk("t2b_ovf", ovf, 1);
    drain();

    // Back-to-back beats at full throughput
    fire_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] av;
      av = W'(i * 16'h1111);
      issue(av, 16'h0F0F, 1'b0, 1'(i % 2));
    end
    in_valid = 1'b0;
    chk("b2b_issue_cycles", cyc - c0, 8);
    drain();
    chk("b2b_count", fire_cyc.size(), 8);
    for (int j = 1; j < fire_cyc.size(); j++) begin
      chk("b2b_gap", fire_cyc[j] - fire_cyc[j-1], 1);
    end

    // Backpressure: consumer stalls for six cycles
    o0 = n_out;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          issue(W'(16'h1234 + i * 16'h0101), W'(16'h0F00 + i), 1'(i % 2), 1'(i / 3));
        end
        in_valid = 1'b0;
      end
      begin
        wait_out("bp_wait");
        held = sum;
        for (int i = 0; i < 6; i++) begin
          chk("bp_in_ready", in_ready, 0);
          chk("bp_valid_held", out_valid, 1);
          chk("bp_sum_held", sum, held);
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_delivered", n_out - o0, 5);

    // Reset while three beats are in flight
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    issue(16'h3333, 16'h0101, 1'b1, 1'b0);
    issue(16'h5555, 16'h0005, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("no_stale", out_valid, 0);
      step();
    end
    measure_latency("t5", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    drain();

    // Randomized regression with random backpressure
    i0 = n_in;
    o0 = n_out;
    issued = 0;
    guard = 0;
    in_valid = 1'b0;
    while (issued < NRAND && guard < 60000) begin
      if (!in_valid && $urandom_range(3) != 0) begin
        a = pick();
        b = pick();
        cin = 1'($urandom_range(1));
        sub = 1'($urandom_range(1));
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(1));
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      guard++;
      if (acc) begin
        issued++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("rand_issued", issued, NRAND);
    drain();
    chk("rand_in_count", n_in - i0, issued);
    chk("rand_out_count", n_out - o0, n_in - i0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
